i2c_codec_target: RTL
=====================

# i2c_codec_target

I2C write-only target (responder) modelling the audio codec's control port on a two-wire bus. Detects START/STOP, matches its 7-bit device address, ACKs address and data bytes, and decodes each 2-byte payload into a 7-bit register address and 9-bit value. Stores the values in a local register file. Sits on the codec side of the bus opposite the board-level initializer; serves as the in-system codec stand-in for simulation and FPGA loopback checks.

## Interface
- DEV_ADDR, 7'h1A, device address matched on the first byte
- NUM_REGS, 10, number of stored registers (addresses 0..NUM_REGS-1)
- i_clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_sclk  input  1  bus SCL (asynchronous, synchronized internally)
- i_sdat  input  1  bus SDA as seen on the pin (asynchronous)
- o_sdat_oe  output  1  1 = drive SDA low (ACK); 0 = release
- o_wr_valid  output  1  one-cycle pulse per accepted register write
- o_wr_addr  output  7  register address of the last write
- o_wr_data  output  9  register value of the last write
- o_regs  output  9*NUM_REGS  register file, reg k at bits [9k+8:9k]
- o_busy  output  1  1 between a START and the following STOP

## Operation
- Input path: 2-flop synchronizer on each of i_sclk and i_sdat, then a 1-flop history register for edge detection.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
- IDLE: waits for START, then goes to ADDR with the bit counter at 0.
- ADDR, BYTE1, BYTE2: sample SDA on each SCL rising edge, MSB first, 8 bits per byte.
- After the 8th address bit:
  - If the address equals DEV_ADDR and R/W=0, go to ACK_A.
  - Otherwise go to IGNORE; no ACK is driven.
- ACK states:
  - o_sdat_oe rises on the SCL falling edge that follows the 8th bit.
  - o_sdat_oe falls on the next SCL falling edge (end of the 9th clock).
  - The FSM then advances ACK_A→BYTE1, ACK_1→BYTE2, ACK_2→IGNORE.
- Payload format: {byte1, byte2} = {addr[6:0], data[8:0]}.
- Write commit happens at entry to ACK_2:
  - o_wr_valid pulses for 1 cycle and o_wr_addr/o_wr_data update.
  - The register file is written only if addr < NUM_REGS. Out-of-range addresses are still ACKed and still pulse o_wr_valid.
- IGNORE: holds o_sdat_oe=0. Any further bytes in the same transaction are not ACKed (NACK).
- STOP in any state → IDLE, o_sdat_oe=0. A partially received payload is discarded with no write.
- START (including a repeated START) in any state → ADDR. The bit counter clears and any partial byte is discarded.
- START/STOP detection takes priority over bit sampling in the same cycle.
- o_busy is 1 from START detection until STOP detection.

## Timing
- Reset values: o_sdat_oe=0, o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_regs=0, o_busy=0, FSM=IDLE.
- Pin-to-event latency is 3 i_clk cycles (2 synchronizer stages + 1 edge stage).
- ACK assertion lags the SCL falling edge by 3 cycles, so the ACK is valid well before the next SCL rise.
- Bus requirement: SCL high and low phases ≥ 4 i_clk cycles each. SDA must not change within 3 cycles of an SCL edge, except for START/STOP.
- o_wr_valid is coincident with the cycle o_sdat_oe rises in ACK_2. o_regs reflects the new value on the following cycle.
- i_rst asserted mid-transaction: all state returns to reset values on the next edge and the bus is released. The partial transaction is lost; the next START is handled normally.

## Configuration
- Macro: I2C_CODEC_TARGET_RESET_REG_EN.
- Defined: a commit to address 7'h0F with data 9'h000 clears every o_regs entry to 0 instead of storing. o_wr_valid still pulses with addr 0x0F.
- Not defined: address 0x0F is treated as an ordinary out-of-range write (ACK + pulse, no storage).

## Test plan
- Write bytes 0x34, 0x01, 0x97 framed by START/STOP:
  - Three ACKs.
  - o_wr_valid pulse with addr=0x00, data=9'h197.
  - o_regs[8:0]=9'h197.
- Address byte 0x36 followed by two bytes: no ACK on any byte, no o_wr_valid, o_regs unchanged.
- Address byte 0x35 (read): NACK, state IGNORE until STOP, o_busy falls on STOP.
- Bytes 0x34, 0x12, then STOP after 4 bits of byte2: two ACKs, no write.
- Bytes 0x34, 0x12, then repeated START after 4 bits of byte2, then 0x34, 0x12, 0x01 and STOP:
  - Exactly one write, addr=0x09, data=9'h001.
- With the macro defined: load reg0=9'h197, then write 0x34, 0x1E, 0x00. All o_regs become 0 and o_wr_valid pulses with addr 0x0F.

Source files
------------

// File: rtl/i2c_codec_target_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_codec_target_if
//  Description : Bus bundle between the I2C codec target and its environment.
//                Carries the two-wire pins, the ACK drive, the write-commit
//                strobe and the flattened register file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_codec_target_if #(
    parameter int NUM_REGS = 10
);
    logic                    i_sclk;
    logic                    i_sdat;
    logic                    o_sdat_oe;
    logic                    o_wr_valid;
    logic [6:0]              o_wr_addr;
    logic [8:0]              o_wr_data;
    logic [9*NUM_REGS-1:0]   o_regs;
    logic                    o_busy;

    // Target side: receives the pins, produces everything else
    modport slave (
        input  i_sclk,
        input  i_sdat,
        output o_sdat_oe,
        output o_wr_valid,
        output o_wr_addr,
        output o_wr_data,
        output o_regs,
        output o_busy
    );

    // Bus-driver / observer side
    modport master (
        output i_sclk,
        output i_sdat,
        input  o_sdat_oe,
        input  o_wr_valid,
        input  o_wr_addr,
        input  o_wr_data,
        input  o_regs,
        input  o_busy
    );
endinterface
`default_nettype wire

// File: rtl/i2c_codec_target.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_codec_target
//  Description : Write-only I2C target standing in for an audio codec control
//                port. Matches a 7-bit device address, ACKs address and both
//                payload bytes, decodes {addr[6:0], data[8:0]} and stores the
//                value in a local register file.
//  Options     : I2C_CODEC_TARGET_RESET_REG_EN - a write of 9'h000 to register
//                address 7'h0F clears the whole register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NUM_REGS = 10
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    i2c_codec_target_if.slave      bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK_A  = 3'd2,
        ST_BYTE1  = 3'd3,
        ST_ACK_1  = 3'd4,
        ST_BYTE2  = 3'd5,
        ST_ACK_2  = 3'd6,
        ST_IGNORE = 3'd7
    } state_t;

    localparam logic [6:0] c_CLR_ADDR = 7'h0F;

    // Synchronizers and edge history
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    // FSM and datapath state
    state_t     state_q,    state_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] shift_q,    shift_d;
    logic [7:0] byte1_q,    byte1_d;
    logic       oe_q,       oe_d;
    logic       wr_valid_q, wr_valid_d;
    logic [6:0] wr_addr_q,  wr_addr_d;
    logic [8:0] wr_data_q,  wr_data_d;
    logic       busy_q,     busy_d;
    logic [8:0] regs_q [NUM_REGS];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    // Bring the asynchronous pins into the clock domain and keep one sample of history
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_h_q <= 1'b1;
            sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_h_q <= 1'b1;
        end else begin
            scl_s1_q <= bus.i_sclk; scl_s2_q <= scl_s1_q; scl_h_q <= scl_s2_q;
            sda_s1_q <= bus.i_sdat; sda_s2_q <= sda_s1_q; sda_h_q <= sda_s2_q;
        end
    end

    assign w_scl_rise = scl_s2_q & ~scl_h_q;
    assign w_scl_fall = ~scl_s2_q & scl_h_q;
    // SDA may only move while SCL is high for START (fall) or STOP (rise)
    assign w_start    = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign w_stop     = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
    // Byte as it stands once the current bit is shifted in
    assign w_byte     = {shift_q[6:0], sda_s2_q};

    // Next-state and datapath decode; bus conditions override bit handling
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte1_d    = byte1_q;
        oe_d       = oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;

        if (w_start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
            oe_d      = 1'b0;
            busy_d    = 1'b1;
        end else if (w_stop) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                    if (w_scl_rise) begin
                        shift_d = w_byte;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            case (state_q)
                                ST_ADDR:  state_d = (w_byte[7:1] == DEV_ADDR && !w_byte[0])
                                                    ? ST_ACK_A : ST_IGNORE;
                                ST_BYTE1: begin
                                    state_d = ST_ACK_1;
                                    byte1_d = w_byte;
                                end
                                default:  state_d = ST_ACK_2;
                            endcase
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_ACK_A, ST_ACK_1, ST_ACK_2: begin
                    // First SCL fall grabs SDA, the second one (end of 9th clock) lets go
                    if (w_scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                            if (state_q == ST_ACK_2) begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = byte1_q[7:1];
                                wr_data_d  = {byte1_q[0], shift_q};
                            end
                        end else begin
                            oe_d = 1'b0;
                            case (state_q)
                                ST_ACK_A: state_d = ST_BYTE1;
                                ST_ACK_1: state_d = ST_BYTE2;
                                default:  state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: oe_d = 1'b0;
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            byte1_q    <= 8'h00;
            oe_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 7'h00;
            wr_data_q  <= 9'h000;
            busy_q     <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte1_q    <= byte1_d;
            oe_q       <= oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    // Register file follows the commit strobe by one cycle; unmatched addresses store nothing
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 9'h000;
        end else if (wr_valid_q) begin
`ifdef I2C_CODEC_TARGET_RESET_REG_EN
            if (wr_addr_q == c_CLR_ADDR && wr_data_q == 9'h000) begin
                for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 9'h000;
            end else begin
                for (int k = 0; k < NUM_REGS; k++)
                    if (wr_addr_q == 7'(k)) regs_q[k] <= wr_data_q;
            end
`else
            for (int k = 0; k < NUM_REGS; k++)
                if (wr_addr_q == 7'(k) && wr_addr_q != c_CLR_ADDR) regs_q[k] <= wr_data_q;
`endif
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
            assign bus.o_regs[9*k +: 9] = regs_q[k];
        end
    endgenerate

    assign bus.o_sdat_oe  = oe_q;
    assign bus.o_wr_valid = wr_valid_q;
    assign bus.o_wr_addr  = wr_addr_q;
    assign bus.o_wr_data  = wr_data_q;
    assign bus.o_busy     = busy_q;

endmodule
`default_nettype wire
